alu_rs: RTL
===========

Name: alu_rs

Overview:
- Reservation station and issue scheduler in front of the integer ALU.
- Accepts one decoded ALU op per cycle from dispatch and holds it until both operands are valid.
- Captures operand values from two result-broadcast (CDB) ports.
- Issues at most one ready entry per cycle to the ALU as a registered valid/operand/tag bundle.

Parameters:
- RS_SIZE, 8, number of entries (power of two, ≥2).
- RS_IDX_WIDTH, 3, log2(RS_SIZE).
- ROB_W, 4, ROB tag width (matches `ROB_SIZE_WIDTH).
- OP_W, 4, L1 opcode width (matches `CALC_OP_L1_NUM_WIDTH).

Ports:
- clk_in  in  1  clock
- rst_in  in  1  synchronous reset, active-low (reset when rst_in==0 at posedge)
- rdy_in  in  1  global ready; 0 freezes all state
- need_flush_in  in  1  mispredict flush
- disp_valid_in  in  1  dispatch request
- disp_op_L1_in  in  OP_W  ALU L1 opcode
- disp_op_L2_in  in  1  ALU L2 opcode (sub/sra select)
- disp_vj_in  in  32  operand1 value (meaningful when disp_qj_busy_in==0)
- disp_qj_in  in  ROB_W  operand1 producer tag
- disp_qj_busy_in  in  1  operand1 pending
- disp_vk_in, disp_qk_in, disp_qk_busy_in  in  32/ROB_W/1  same for operand2
- disp_dest_in  in  ROB_W  destination ROB tag
- full_out  out  1  all entries busy
- cdb0_valid_in, cdb0_tag_in, cdb0_value_in  in  1/ROB_W/32  broadcast port 0 (ALU result)
- cdb1_valid_in, cdb1_tag_in, cdb1_value_in  in  1/ROB_W/32  broadcast port 1 (load/store result)
- alu_valid_out  out  1  issue valid to ALU
- alu_opr1_out, alu_opr2_out  out  32  operands
- alu_dep_out  out  ROB_W  destination tag
- alu_op_L1_out  out  OP_W  L1 opcode
- alu_op_L2_out  out  1  L2 opcode

Behaviour:
- Per-entry state: busy, op_L1, op_L2, vj, qj, qj_busy, vk, qk, qk_busy, dest.
- Reset (rst_in==0): all busy=0; alu_valid_out=0; other outputs 0; full_out=0.
- rdy_in==0 and not in reset: no state change; outputs hold.
- full_out: combinational AND of all busy bits (registered state only).
- Dispatch:
  - Taken when disp_valid_in && !full_out && !need_flush_in.
  - Written into the lowest-index free entry.
  - disp_valid_in while full_out is dropped; a same-cycle issue does not free space for that dispatch.
- Dispatch bypass: if a disp operand is busy and a CDB port in the same cycle carries a matching tag, store the value with busy=0.
- Wakeup: every busy entry with qj_busy && cdbN_valid_in && qj==cdbN_tag_in latches the value and clears qj_busy (same for k).
- Both CDB ports matching the same operand: port 0 wins.
- Issue select:
  - Uses start-of-cycle state: an entry is ready when busy && !qj_busy && !qk_busy.
  - Wakeup in cycle N makes the entry issuable in N+1, so minimum dispatch-to-alu_valid_out latency is 2 cycles for ready operands.
  - Selected entry: outputs registered at the edge, alu_valid_out=1, entry busy cleared at the same edge.
  - No ready entry: alu_valid_out=0 next cycle.
- Flush (need_flush_in==1, rdy_in==1):
  - All busy cleared and alu_valid_out=0 at the edge.
  - Same-cycle dispatch and issue suppressed.
- Dispatch into an entry freed by issue in the same cycle is not allowed; lowest-free is computed from start-of-cycle busy bits.
- Tags compare full ROB_W bits; no wrap handling needed (the ROB guarantees unique live tags).

Optional Feature:
- ALU_RS_OLDEST_FIRST_EN
  - Defined: each entry carries an RS_IDX_WIDTH+1-bit age stamp from a dispatch counter that increments on every accepted dispatch and wraps. Issue picks the ready entry with the oldest stamp (wrap-aware compare, valid because live entries span < RS_SIZE+1 stamps). The counter resets to 0 on reset and flush.
  - Undefined: fixed priority, lowest-index ready entry issues.

Test Plan:
- Reset low 2 cycles, dispatch ADD vj=5 vk=7 both ready dest=3 -> cycle+2: alu_valid_out=1, opr1=5, opr2=7, dep=3, op_L1=0, op_L2=0; following cycle alu_valid_out=0.
- Dispatch SUB qj=2 busy, vk=1; two cycles later cdb1 tag=2 value=0x10 -> issue the cycle after the broadcast with opr1=0x10; no issue earlier.
- Dispatch with qk=4 busy while cdb0 tag=4 value=9 in the same cycle -> entry stored ready, issues cycle+2 with opr2=9.
- Fill 8 ready-blocked entries -> full_out=1; a 9th dispatch is dropped; wake one -> it issues, full_out falls the cycle after issue.
- 3 entries pending, flush asserted -> next cycle full_out=0, alu_valid_out=0; late CDB matching old tags causes no issue.
- Entries idx0 (dispatched later) and idx5 (dispatched earlier) woken in the same cycle -> with ALU_RS_OLDEST_FIRST_EN idx5 issues first, without it idx0 issues first; rdy_in low mid-sequence freezes outputs.

Source files
------------

// File: rtl/alu_rs.sv
// alu_rs: reservation station + issue scheduler for the integer ALU.
// Define ALU_RS_OLDEST_FIRST_EN for oldest-first issue; default is lowest-index-first.
module alu_rs #(
    parameter int RS_SIZE      = 8,
    parameter int RS_IDX_WIDTH = 3,
    parameter int ROB_W        = 4,
    parameter int OP_W         = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             need_flush_in,
    input  logic             disp_valid_in,
    input  logic [OP_W-1:0]  disp_op_L1_in,
    input  logic             disp_op_L2_in,
    input  logic [31:0]      disp_vj_in,
    input  logic [ROB_W-1:0] disp_qj_in,
    input  logic             disp_qj_busy_in,
    input  logic [31:0]      disp_vk_in,
    input  logic [ROB_W-1:0] disp_qk_in,
    input  logic             disp_qk_busy_in,
    input  logic [ROB_W-1:0] disp_dest_in,
    output logic             full_out,
    input  logic             cdb0_valid_in,
    input  logic [ROB_W-1:0] cdb0_tag_in,
    input  logic [31:0]      cdb0_value_in,
    input  logic             cdb1_valid_in,
    input  logic [ROB_W-1:0] cdb1_tag_in,
    input  logic [31:0]      cdb1_value_in,
    output logic             alu_valid_out,
    output logic [31:0]      alu_opr1_out,
    output logic [31:0]      alu_opr2_out,
    output logic [ROB_W-1:0] alu_dep_out,
    output logic [OP_W-1:0]  alu_op_L1_out,
    output logic             alu_op_L2_out
);
    logic [RS_SIZE-1:0] busy_q, qjb_q, qkb_q, op2_q, ready;
    logic [OP_W-1:0] op1_q [RS_SIZE];
    logic [31:0] vj_q [RS_SIZE];
    logic [31:0] vk_q [RS_SIZE];
    logic [ROB_W-1:0] qj_q [RS_SIZE];
    logic [ROB_W-1:0] qk_q [RS_SIZE];
    logic [ROB_W-1:0] dest_q [RS_SIZE];
    logic alu_valid_q, alu_op2_q;
    logic [31:0] alu_opr1_q, alu_opr2_q;
    logic [ROB_W-1:0] alu_dep_q;
    logic [OP_W-1:0] alu_op1_q;
    logic [RS_IDX_WIDTH-1:0] free_idx, sel_idx;
    logic sel_found, take, qjb_d, qkb_d;
    logic [31:0] vj_d, vk_d;
`ifdef ALU_RS_OLDEST_FIRST_EN
    logic [RS_IDX_WIDTH:0] cnt_q, best_d, dist;
    logic [RS_IDX_WIDTH:0] age_q [RS_SIZE];
`endif

    function automatic logic hit(input logic v, input logic [ROB_W-1:0] a, input logic [ROB_W-1:0] b);
        return v && a == b;
    endfunction

    assign full_out      = &busy_q;
    assign take          = disp_valid_in && !full_out && !need_flush_in;
    assign alu_valid_out = alu_valid_q;
    assign alu_opr1_out  = alu_opr1_q;
    assign alu_opr2_out  = alu_opr2_q;
    assign alu_dep_out   = alu_dep_q;
    assign alu_op_L1_out = alu_op1_q;
    assign alu_op_L2_out = alu_op2_q;

    always_comb begin
        ready = busy_q & ~qjb_q & ~qkb_q;
        free_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--)
            if (!busy_q[i]) free_idx = i[RS_IDX_WIDTH-1:0];
        sel_found = 1'b0;
        sel_idx = '0;
`ifdef ALU_RS_OLDEST_FIRST_EN
        // distance back from the dispatch counter: larger means older, wrap-safe
        best_d = '0;
        dist = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            dist = cnt_q - age_q[i];
            if (ready[i] && (!sel_found || dist > best_d)) begin
                sel_found = 1'b1;
                sel_idx = i[RS_IDX_WIDTH-1:0];
                best_d = dist;
            end
        end
`else
        for (int i = 0; i < RS_SIZE; i++)
            if (ready[i] && !sel_found) begin
                sel_found = 1'b1;
                sel_idx = i[RS_IDX_WIDTH-1:0];
            end
`endif
        qjb_d = disp_qj_busy_in && !hit(cdb0_valid_in, cdb0_tag_in, disp_qj_in) && !hit(cdb1_valid_in, cdb1_tag_in, disp_qj_in);
        qkb_d = disp_qk_busy_in && !hit(cdb0_valid_in, cdb0_tag_in, disp_qk_in) && !hit(cdb1_valid_in, cdb1_tag_in, disp_qk_in);
        vj_d = !disp_qj_busy_in ? disp_vj_in :
               hit(cdb0_valid_in, cdb0_tag_in, disp_qj_in) ? cdb0_value_in :
               hit(cdb1_valid_in, cdb1_tag_in, disp_qj_in) ? cdb1_value_in : disp_vj_in;
        vk_d = !disp_qk_busy_in ? disp_vk_in :
               hit(cdb0_valid_in, cdb0_tag_in, disp_qk_in) ? cdb0_value_in :
               hit(cdb1_valid_in, cdb1_tag_in, disp_qk_in) ? cdb1_value_in : disp_vk_in;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            busy_q      <= '0;
            alu_valid_q <= 1'b0;
            alu_opr1_q  <= '0;
            alu_opr2_q  <= '0;
            alu_dep_q   <= '0;
            alu_op1_q   <= '0;
            alu_op2_q   <= 1'b0;
`ifdef ALU_RS_OLDEST_FIRST_EN
            cnt_q       <= '0;
`endif
        end else if (rdy_in) begin
            if (need_flush_in) begin
                busy_q      <= '0;
                alu_valid_q <= 1'b0;
`ifdef ALU_RS_OLDEST_FIRST_EN
                cnt_q       <= '0;
`endif
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy_q[i] && qjb_q[i] && (hit(cdb0_valid_in, cdb0_tag_in, qj_q[i]) || hit(cdb1_valid_in, cdb1_tag_in, qj_q[i]))) begin
                        qjb_q[i] <= 1'b0;
                        vj_q[i]  <= hit(cdb0_valid_in, cdb0_tag_in, qj_q[i]) ? cdb0_value_in : cdb1_value_in;
                    end
                    if (busy_q[i] && qkb_q[i] && (hit(cdb0_valid_in, cdb0_tag_in, qk_q[i]) || hit(cdb1_valid_in, cdb1_tag_in, qk_q[i]))) begin
                        qkb_q[i] <= 1'b0;
                        vk_q[i]  <= hit(cdb0_valid_in, cdb0_tag_in, qk_q[i]) ? cdb0_value_in : cdb1_value_in;
                    end
                end
                alu_valid_q <= sel_found;
                if (sel_found) begin
                    busy_q[sel_idx] <= 1'b0;
                    alu_opr1_q      <= vj_q[sel_idx];
                    alu_opr2_q      <= vk_q[sel_idx];
                    alu_dep_q       <= dest_q[sel_idx];
                    alu_op1_q       <= op1_q[sel_idx];
                    alu_op2_q       <= op2_q[sel_idx];
                end
                if (take) begin
                    busy_q[free_idx] <= 1'b1;
                    op1_q[free_idx]  <= disp_op_L1_in;
                    op2_q[free_idx]  <= disp_op_L2_in;
                    vj_q[free_idx]   <= vj_d;
                    qj_q[free_idx]   <= disp_qj_in;
                    qjb_q[free_idx]  <= qjb_d;
                    vk_q[free_idx]   <= vk_d;
                    qk_q[free_idx]   <= disp_qk_in;
                    qkb_q[free_idx]  <= qkb_d;
                    dest_q[free_idx] <= disp_dest_in;
`ifdef ALU_RS_OLDEST_FIRST_EN
                    age_q[free_idx]  <= cnt_q;
                    cnt_q            <= cnt_q + 1'b1;
`endif
                end
            end
        end
    end
endmodule
